// File: rtl/rv_mdu_if.sv
// rv_mdu_if: request/operand/result bundle between the execute stage and rv_mdu.
// The pipeline side uses the master modport; the multiply/divide unit uses slave.
interface rv_mdu_if #(
  parameter int XLEN = 32
);
  logic            mdu_req_i;
  logic [2:0]      mdu_op_i;
  logic [XLEN-1:0] mdu_port_a_i;
  logic [XLEN-1:0] mdu_port_b_i;
  logic            mdu_kill_i;
  logic [XLEN-1:0] mdu_result_o;
  logic            mdu_valid_o;
  logic            mdu_stall_req_o;

  modport master (
    output mdu_req_i, mdu_op_i, mdu_port_a_i, mdu_port_b_i, mdu_kill_i,
    input  mdu_result_o, mdu_valid_o, mdu_stall_req_o
  );

  modport slave (
    input  mdu_req_i, mdu_op_i, mdu_port_a_i, mdu_port_b_i, mdu_kill_i,
    output mdu_result_o, mdu_valid_o, mdu_stall_req_o
  );
endinterface

// File: rtl/rv_mdu.sv
// rv_mdu: multi-cycle RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiplier and restoring divider, RISC-V div-by-zero and
// overflow results, stall request held until the one-cycle valid pulse.
// Optional macro RV_MDU_FAST_MUL_EN: multiplies done by a single registered
// signed multiply at acceptance (valid one cycle later); division unchanged.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for mdu_req_i; operands latched on acceptance
// MUL    | shift-add iterations, one multiplier bit per cycle
// DIV    | restoring iterations, one quotient bit per cycle, MSB first
// DONE   | result presented with mdu_valid_o for one cycle
module rv_mdu #(
  parameter int XLEN = 32
) (
  input logic     clk_i,
  input logic     arstn_i,
  rv_mdu_if.slave mdu
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CW-1:0]   CNT_TOP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   divisor;
  logic              neg_q;
  logic              neg_r;
`ifndef RV_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
`endif

  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  // Operand decode at acceptance: which operands are signed, their signs and magnitudes.
  assign signed_a = (mdu.mdu_op_i == 3'b001) | (mdu.mdu_op_i == 3'b010) |
                    (mdu.mdu_op_i == 3'b100) | (mdu.mdu_op_i == 3'b110);
  assign signed_b = (mdu.mdu_op_i == 3'b001) | (mdu.mdu_op_i == 3'b100) |
                    (mdu.mdu_op_i == 3'b110);
  assign sign_a   = signed_a & mdu.mdu_port_a_i[XLEN-1];
  assign sign_b   = signed_b & mdu.mdu_port_b_i[XLEN-1];
  // |INT_MIN| wraps back to INT_MIN, which is the correct unsigned magnitude.
  assign mag_a    = sign_a ? -mdu.mdu_port_a_i : mdu.mdu_port_a_i;
  assign mag_b    = sign_b ? -mdu.mdu_port_b_i : mdu.mdu_port_b_i;
  assign div_zero = (mdu.mdu_port_b_i == '0);
  // op[0]=0 among divide ops selects the signed DIV/REM pair.
  assign div_ovf  = ~mdu.mdu_op_i[0] & (mdu.mdu_port_a_i == INT_MIN) &
                    (mdu.mdu_port_b_i == '1);

`ifdef RV_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b;
  // 33-bit signed operands sign-extended to 2*XLEN; the low 2*XLEN product bits are exact.
  assign fast_a = {{XLEN{sign_a}}, mdu.mdu_port_a_i};
  assign fast_b = {{XLEN{sign_b}}, mdu.mdu_port_b_i};
`endif

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;
  // Restoring step: bring the next dividend bit into the XLEN+1-bit partial remainder.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
  end

  // Control and datapath registers; kill clears everything just like reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      acc     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`ifndef RV_MDU_FAST_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
`endif
    end else if (mdu.mdu_kill_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      acc     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`ifndef RV_MDU_FAST_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (mdu.mdu_req_i) begin
            op_q <= mdu.mdu_op_i;
            if (!mdu.mdu_op_i[2]) begin
`ifdef RV_MDU_FAST_MUL_EN
              acc   <= fast_a * fast_b;
              neg_q <= 1'b0;
              state <= S_DONE;
`else
              acc    <= '0;
              mcand  <= {{XLEN{1'b0}}, mag_a};
              mplier <= mag_b;
              neg_q  <= sign_a ^ sign_b;
              cnt    <= CNT_TOP;
              state  <= S_MUL;
`endif
            end else if (div_zero) begin
              // Final values loaded directly; no sign fix-up applied in DONE.
              quo   <= '1;
              rem   <= mdu.mdu_port_a_i;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else if (div_ovf) begin
              quo   <= INT_MIN;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else begin
              quo     <= mag_a;
              rem     <= '0;
              divisor <= mag_b;
              neg_q   <= sign_a ^ sign_b;
              neg_r   <= sign_a;
              cnt     <= CNT_TOP;
              state   <= S_DIV;
            end
          end
        end
`ifndef RV_MDU_FAST_MUL_EN
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= {mcand[2*XLEN-2:0], 1'b0};
          mplier <= {1'b0, mplier[XLEN-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == '0) state <= S_DONE;
        end
`endif
        S_DIV: begin
          if (!trial[XLEN+1]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res;
  // Sign fix-up and result selection from the finished accumulators.
  always_comb begin
    prod = neg_q ? -acc : acc;
    res  = '0;
    if (op_q[2]) begin
      if (op_q[1]) res = neg_r ? -rem : rem;
      else         res = neg_q ? -quo : quo;
    end else begin
      res = (op_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  assign mdu.mdu_valid_o     = (state == S_DONE) & ~mdu.mdu_kill_i;
  assign mdu.mdu_result_o    = mdu.mdu_valid_o ? res : '0;
  assign mdu.mdu_stall_req_o = mdu.mdu_req_i & ~mdu.mdu_valid_o & ~mdu.mdu_kill_i;
endmodule
